// File: rtl/seq_detect_param_mealy.sv
// -----------------------------------------------------------------------------
// seq_detect_param_mealy
//
// Parametrised Mealy serial-pattern detector. It watches a qualified serial bit
// stream and flags, in the same cycle, the bit that completes the active N-bit
// pattern (MSB of the pattern is the oldest bit). The pattern can be replaced
// at run time, and a saturating hit counter tracks the number of matches.
//
// Parameters
//   N        pattern length in bits (2..16)
//   PATTERN  pattern in force after reset, MSB received first
//   OVERLAP  1: a match may reuse bits of the previous match
//            0: history is discarded after each match
//   CNT_W    hit counter width
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   x_valid   x carries a stream bit this cycle
//   x         serial input bit
//   pat_load  replace the pattern with pat_in; x is ignored this cycle
//   pat_in    new pattern, MSB first
//   cnt_clr   synchronous clear of hit_cnt and cnt_sat (wins over a match)
//   y         combinational match, same cycle as the completing bit
//   y_q       y delayed by one clock
//   hit_cnt   saturating match count
//   cnt_sat   hit_cnt is all-ones (sticky until cnt_clr)
// -----------------------------------------------------------------------------
module seq_detect_param_mealy #(
  parameter int           N       = 5,
  parameter logic [N-1:0] PATTERN = 5'b11011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             cnt_sat
);

  // fill counts 0..N-1, so clog2(N) bits always suffice (N >= 2).
  localparam int              FILL_W    = $clog2(N);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

  logic [N-1:0]       pat;
  logic [N-2:0]       hist;     // last N-1 valid bits, newest in the LSB
  logic [FILL_W-1:0]  fill;     // how many of those bits are meaningful
  logic [N-1:0]       window;   // candidate pattern formed with the current bit
  logic               match;
  logic [CNT_W-1:0]   cnt_next;

  assign window = {hist, x};

  // A load cycle never matches: the incoming x belongs to the old pattern's
  // stream and detection restarts from empty history.
  assign match = x_valid & ~pat_load & (fill == FILL_FULL) & (window == pat);

  // fill is already 0 while rst is low; gating keeps y quiet even if the
  // inputs wiggle during reset.
  assign y = match & rst;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = hit_cnt;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (match && !(&hit_cnt)) begin
      cnt_next = hit_cnt + CNT_W'(1);
    end
  end

  // Pattern, history and fill tracking.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      fill <= '0;
    end else if (x_valid) begin
      // hist keeps shifting after a non-overlapping match; the cleared fill
      // makes the stale bits invisible until N-1 new ones have arrived.
      hist <= window[N-2:0];
      if (match && !OVERLAP) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Registered outputs. cnt_sat is derived from the next count, which makes it
  // sticky: the count cannot leave all-ones except through cnt_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q     <= 1'b0;
      hit_cnt <= '0;
      cnt_sat <= 1'b0;
    end else begin
      y_q     <= match;
      hit_cnt <= cnt_next;
      cnt_sat <= &cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_detect_param_mealy.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param_mealy
//
// Three detector instances share one stimulus stream:
//   u0: defaults (OVERLAP=1, CNT_W=8)
//   u1: OVERLAP=0
//   u2: CNT_W=2 (saturation)
// A behavioural model keeps, per instance, a queue of the valid bits seen since
// detection last restarted and compares the newest N bits against the pattern
// as plain integers. Every negedge, all outputs of all instances are compared
// to that model. Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_seq_detect_param_mealy;

  localparam int         N         = 5;
  localparam logic [4:0] RESET_PAT = 5'b11011;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       x_valid  = 1'b0;
  logic       x        = 1'b0;
  logic       pat_load = 1'b0;
  logic [4:0] pat_in   = 5'b0;
  logic       cnt_clr  = 1'b0;

  logic       y0, y1, y2, yq0, yq1, yq2, s0, s1, s2;
  logic [7:0] hc0, hc1;
  logic [1:0] hc2;

  seq_detect_param_mealy u0 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y0), .y_q(yq0), .hit_cnt(hc0),
    .cnt_sat(s0)
  );

  seq_detect_param_mealy #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y1), .y_q(yq1), .hit_cnt(hc1),
    .cnt_sat(s1)
  );

  seq_detect_param_mealy #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .y(y2), .y_q(yq2), .hit_cnt(hc2),
    .cnt_sat(s2)
  );

  always #5 clk = ~clk;

  // Uniform views of the three instances for the compare loop.
  logic        yv  [3];
  logic        yqv [3];
  logic        sv  [3];
  logic [31:0] hcv [3];
  assign yv[0]  = y0;   assign yv[1]  = y1;   assign yv[2]  = y2;
  assign yqv[0] = yq0;  assign yqv[1] = yq1;  assign yqv[2] = yq2;
  assign sv[0]  = s0;   assign sv[1]  = s1;   assign sv[2]  = s2;
  assign hcv[0] = {24'b0, hc0};
  assign hcv[1] = {24'b0, hc1};
  assign hcv[2] = {30'b0, hc2};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit         hq   [3][$];          // valid bits since last restart, oldest first
  logic [4:0] mpat;
  int         mcnt [3];
  bit         myq  [3];
  int         ovl  [3] = '{1, 0, 1};
  int         cmax [3] = '{255, 255, 3};

  function automatic bit model_match(int i);
    logic [31:0] v;
    if (!rst || !x_valid || pat_load || hq[i].size() != N - 1) return 1'b0;
    v = 0;
    for (int k = 0; k < hq[i].size(); k++) v = (v << 1) | 32'(hq[i][k]);
    v = (v << 1) | 32'(x);
    return v[4:0] == mpat;
  endfunction

  task automatic model_reset();
    mpat = RESET_PAT;
    for (int i = 0; i < 3; i++) begin
      hq[i].delete();
      mcnt[i] = 0;
      myq[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit m [3];
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) m[i] = model_match(i);
    for (int i = 0; i < 3; i++) begin
      myq[i] = m[i];
      if (cnt_clr)                   mcnt[i] = 0;
      else if (m[i] && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
      if (!pat_load && x_valid) begin
        if (m[i] && ovl[i] == 0) begin
          hq[i].delete();
        end else begin
          hq[i].push_back(x);
          if (hq[i].size() > N - 1) void'(hq[i].pop_front());
        end
      end
    end
    if (pat_load) begin
      mpat = pat_in;
      for (int i = 0; i < 3; i++) hq[i].delete();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      model_step();
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d.y", i),       32'(yv[i]),  32'(model_match(i)));
        check($sformatf("u%0d.y_q", i),     32'(yqv[i]), 32'(myq[i]));
        check($sformatf("u%0d.hit_cnt", i), hcv[i],      32'(mcnt[i]));
        check($sformatf("u%0d.cnt_sat", i), 32'(sv[i]),  32'(mcnt[i] == cmax[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge, outputs are
  // looked at on the following falling edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic xb, input logic ld = 1'b0,
                      input logic [4:0] pin = 5'b0, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    x_valid  = v;
    x        = xb;
    pat_load = ld;
    pat_in   = pin;
    cnt_clr  = clr;
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] s1, e0, e1;
    logic [7:0]  s3, e3;
    logic [4:0]  s4;
    int          expc [5] = '{1, 2, 3, 3, 3};
    int          exps [5] = '{0, 0, 1, 1, 1};
    bit          prev;

    // Reset state
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst.y",       32'(y0),  0);
    check("rst.y_q",     32'(yq0), 0);
    check("rst.hit_cnt", 32'(hc0), 0);
    check("rst.cnt_sat", 32'(s0),  0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Test 1/2: overlapping vs non-overlapping on 11011011011
    s1 = 11'b11011011011;
    e0 = 11'b00001001001;
    e1 = 11'b00001000001;
    prev = 1'b0;
    for (int k = 10; k >= 0; k--) begin
      step(1'b1, s1[k]);
      check("t1.u0.y",   32'(y0),  32'(e0[k]));
      check("t1.u1.y",   32'(y1),  32'(e1[k]));
      check("t1.u0.y_q", 32'(yq0), 32'(prev));
      prev = e0[k];
    end
    step(1'b0, 1'b0);
    check("t1.u0.y_q",     32'(yq0), 1);
    check("t1.u0.hit_cnt", 32'(hc0), 3);
    check("t1.u1.hit_cnt", 32'(hc1), 2);

    // Test 3: load 10010 (offered x ignored), then 10010010
    step(1'b1, 1'b1, 1'b1, 5'b10010);
    check("t3.load.y", 32'(y0), 0);
    s3 = 8'b10010010;
    e3 = 8'b00001001;
    for (int k = 7; k >= 0; k--) begin
      step(1'b1, s3[k]);
      check("t3.u0.y", 32'(y0), 32'(e3[k]));
    end
    step(1'b1, 1'b0, 1'b1, RESET_PAT);

    // Test 4: 11011 with 1-3 cycle gaps
    s4 = 5'b11011;
    for (int k = 4; k >= 0; k--) begin
      for (int g = 0; g < 1 + (k % 3); g++) begin
        step(1'b0, 1'($urandom_range(0, 1)));
        check("t4.gap.y", 32'(y0), 0);
      end
      step(1'b1, s4[k]);
      check("t4.bit.y", 32'(y0), 32'(k == 0));
    end

    // Test 5: 2-bit counter saturation and clear-over-match on u2
    step(1'b0, 1'b0, 1'b0, 5'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, RESET_PAT);
    check("t5.clr.hit_cnt", 32'(hc2), 0);
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    for (int m = 0; m < 5; m++) begin
      step(1'b1, 1'b1);
      check("t5.y", 32'(y2), 1);
      step(1'b1, 1'b0);
      check("t5.hit_cnt", 32'(hc2), 32'(expc[m]));
      check("t5.cnt_sat", 32'(s2),  32'(exps[m]));
      step(1'b1, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 5'b0, 1'b1);
    check("t5.clr_match.y",     32'(y2),  1);
    check("t5.clr_match.hit",   32'(hc2), 3);
    step(1'b0, 1'b0);
    check("t5.after_clr.hit_cnt", 32'(hc2), 0);
    check("t5.after_clr.cnt_sat", 32'(s2),  0);
    check("t5.after_clr.y_q",     32'(yq2), 1);

    // Test 6: reset mid-stream discards partial history
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    x_valid = 1'b1;
    x = 1'b1;
    @(negedge clk);
    check("t6.rst.y",       32'(y0),  0);
    check("t6.rst.y_q",     32'(yq0), 0);
    check("t6.rst.hit_cnt", 32'(hc0), 0);
    check("t6.rst.cnt_sat", 32'(s0),  0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6.first.y", 32'(y0), 0);
    for (int k = 4; k >= 0; k--) begin
      step(1'b1, s4[k]);
      check("t6.bit.y", 32'(y0), 32'(k == 0));
    end

    // Randomised phase, including all-zero / all-one patterns and resets
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end else begin
        logic [4:0] pin;
        case ($urandom_range(0, 3))
          0:       pin = 5'b00000;
          1:       pin = 5'b11111;
          default: pin = 5'($urandom);
        endcase
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 59) == 0), pin,
             1'($urandom_range(0, 99) == 0));
      end
    end

    step(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
